// File: rtl/lcd_frame_capture.sv
// lcd_frame_capture
// Sink for the PPU display stream. It tracks the pixel position from the
// hsync/vsync phases and packs four 2-bit shades per byte (first pixel in
// [7:6]). Each byte is written into the framebuffer bank currently being
// filled. Line and frame geometry are checked, and the scan-out bank is
// flipped only when a frame was captured without a geometry error.
module lcd_frame_capture #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 144,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lcd_hsync,
    input  logic              lcd_vsync,
    input  logic              lcd_pixel,
    input  logic [1:0]        lcd_color,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_data,
    output logic              fb_we,
    output logic              fb_bank,
    output logic              frame_done,
    output logic              frame_err,
    output logic              line_err,
    output logic [7:0]        cur_y
);

    localparam int XW = $clog2(WIDTH + 1);

    localparam logic [XW-1:0]     WIDTH_X    = XW'(WIDTH);
    localparam logic [XW-1:0]     X_ONE      = XW'(1);
    localparam logic [7:0]        HEIGHT_Y   = 8'(HEIGHT);
    localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(WIDTH / 4);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        LINE       = 2'd1,
        HBLANK     = 2'd2,
        VBLANK     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic [XW-1:0]     x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic [7:0]        pack_q, pack_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              line_err_q, line_err_d;
    logic              fb_we_q, fb_we_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]        fb_data_q, fb_data_d;
    logic              fb_bank_q, fb_bank_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;

    logic              hs_rise_s, hs_fall_s, vs_rise_s, vs_fall_s;
    logic              line_in_frame_s;
    logic              start_frame_s, end_frame_s;
    logic [7:0]        pack_slot_s;

    // Edges are seen in the cycle the new sync level is first sampled.
    assign hs_rise_s = lcd_hsync & ~hs_q;
    assign hs_fall_s = ~lcd_hsync & hs_q;
    assign vs_rise_s = lcd_vsync & ~vs_q;
    assign vs_fall_s = ~lcd_vsync & vs_q;

    // Lines past the visible height still count but are never written.
    assign line_in_frame_s = (y_q < HEIGHT_Y);

    // Drop the incoming shade into its slot; a new byte starts with zeroed low slots.
    always_comb begin
        pack_slot_s = pack_q;
        case (x_q[1:0])
            2'd0:    pack_slot_s = {lcd_color, 6'b000000};
            2'd1:    pack_slot_s = {pack_q[7:6], lcd_color, 4'b0000};
            2'd2:    pack_slot_s = {pack_q[7:4], lcd_color, 2'b00};
            2'd3:    pack_slot_s = {pack_q[7:2], lcd_color};
            default: pack_slot_s = pack_q;
        endcase
    end

    // Capture state machine: position tracking, byte writes and frame checks.
    always_comb begin
        state_d       = state_q;
        hs_d          = lcd_hsync;
        vs_d          = lcd_vsync;
        x_d           = x_q;
        y_d           = y_q;
        pack_d        = pack_q;
        base_d        = base_q;
        addr_d        = addr_q;
        line_err_d    = line_err_q;
        fb_we_d       = 1'b0;
        fb_addr_d     = fb_addr_q;
        fb_data_d     = fb_data_q;
        fb_bank_d     = fb_bank_q;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        start_frame_s = 1'b0;
        end_frame_s   = 1'b0;

        case (state_q)
            WAIT_FRAME: begin
                // Only a vsync fall proves we are at a frame boundary.
                if (vs_fall_s) begin
                    start_frame_s = 1'b1;
                end else begin
                    start_frame_s = 1'b0;
                end
            end

            LINE: begin
                if (lcd_pixel && !lcd_hsync && !lcd_vsync) begin
                    if (x_q < WIDTH_X) begin
                        pack_d = pack_slot_s;
                        x_d    = x_q + X_ONE;
                        if (x_q[1:0] == 2'd3) begin
                            if (line_in_frame_s) begin
                                fb_we_d   = 1'b1;
                                fb_addr_d = addr_q;
                                fb_data_d = pack_slot_s;
                            end else begin
                                fb_we_d = 1'b0;
                            end
                            addr_d = addr_q + ADDR_ONE;
                        end else begin
                            addr_d = addr_q;
                        end
                    end else begin
                        // Overlong line: the extra pixel is discarded.
                        line_err_d = 1'b1;
                    end
                end else if (hs_rise_s) begin
                    if (x_q != WIDTH_X) begin
                        line_err_d = 1'b1;
                    end else begin
                        line_err_d = line_err_q;
                    end
                    // Short line ending mid-byte: flush it with zero padding.
                    if ((x_q[1:0] != 2'b00) && line_in_frame_s) begin
                        fb_we_d   = 1'b1;
                        fb_addr_d = addr_q;
                        fb_data_d = pack_q;
                    end else begin
                        fb_we_d = 1'b0;
                    end
                    x_d     = {XW{1'b0}};
                    pack_d  = 8'h00;
                    y_d     = (y_q == 8'hFF) ? y_q : (y_q + 8'd1);
                    base_d  = base_q + LINE_BYTES;
                    addr_d  = base_q + LINE_BYTES;
                    state_d = HBLANK;
                end else begin
                    state_d = LINE;
                end
                // The line close above (if any) is folded in before the frame check.
                if (vs_rise_s) begin
                    end_frame_s = 1'b1;
                end else begin
                    end_frame_s = 1'b0;
                end
            end

            HBLANK: begin
                if (vs_rise_s) begin
                    end_frame_s = 1'b1;
                end else if (hs_fall_s && !lcd_vsync) begin
                    state_d = LINE;
                end else begin
                    state_d = HBLANK;
                end
            end

            VBLANK: begin
                if (vs_fall_s) begin
                    start_frame_s = 1'b1;
                end else begin
                    state_d = VBLANK;
                end
            end

            default: begin
                state_d = WAIT_FRAME;
            end
        endcase

        if (start_frame_s) begin
            state_d    = LINE;
            x_d        = {XW{1'b0}};
            y_d        = 8'h00;
            pack_d     = 8'h00;
            base_d     = {ADDR_W{1'b0}};
            addr_d     = {ADDR_W{1'b0}};
            line_err_d = 1'b0;
        end else if (end_frame_s) begin
            state_d = VBLANK;
            if ((y_d == HEIGHT_Y) && !line_err_d) begin
                frame_done_d = 1'b1;
                fb_bank_d    = ~fb_bank_q;
            end else begin
                frame_err_d = 1'b1;
            end
        end else begin
            fb_bank_d = fb_bank_q;
        end
    end

    // State and output registers; reset discards any pending write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= WAIT_FRAME;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            x_q          <= {XW{1'b0}};
            y_q          <= 8'h00;
            pack_q       <= 8'h00;
            base_q       <= {ADDR_W{1'b0}};
            addr_q       <= {ADDR_W{1'b0}};
            line_err_q   <= 1'b0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= {ADDR_W{1'b0}};
            fb_data_q    <= 8'h00;
            fb_bank_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pack_q       <= pack_d;
            base_q       <= base_d;
            addr_q       <= addr_d;
            line_err_q   <= line_err_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            fb_bank_q    <= fb_bank_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign fb_we      = fb_we_q;
    assign fb_bank    = fb_bank_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign line_err   = line_err_q;
    assign cur_y      = y_q;

endmodule

// File: doc/lcd_frame_capture.md
Name: lcd_frame_capture

Overview:
Sink for the PPU display stream (lcd_hsync, lcd_vsync, lcd_pixel, lcd_color). It reconstructs pixel x/y position from the sync phases and packs four 2-bit pixels per byte. Bytes are written into a double-buffered framebuffer RAM that the video scan-out reads. It also checks line and frame geometry and reports completed frames, so the scan-out only flips to fully captured frames.

Parameters:
WIDTH, 160, active pixels per line; must be a multiple of 4
HEIGHT, 144, active lines per frame
ADDR_W, 13, framebuffer byte-address width; 2^ADDR_W >= WIDTH*HEIGHT/4

Ports:
clk  in  1  system clock, same domain as the PPU
rst  in  1  reset, synchronous, active-low
lcd_hsync  in  1  high during horizontal blank
lcd_vsync  in  1  high during vertical blank
lcd_pixel  in  1  lcd_color is valid this cycle
lcd_color  in  2  shade 0..3
fb_addr  out  ADDR_W  byte address within the write bank
fb_data  out  8  packed pixels
fb_we  out  1  one-cycle write strobe
fb_bank  out  1  bank being written; scan-out reads ~fb_bank
frame_done  out  1  one-cycle pulse, good frame completed
frame_err  out  1  one-cycle pulse, bad frame completed
line_err  out  1  sticky within frame, at least one malformed line
cur_y  out  8  lines completed in the current frame

Behaviour:
- Reset (rst=0 at posedge): state WAIT_FRAME; all outputs 0; x, y, pack register, line base and byte address cleared; sync history registers cleared to 0. Any pending write is discarded.
- Edge detection: compares the current sync input against a registered copy. Edges are therefore seen in the cycle the new level is first sampled.
- States: WAIT_FRAME, LINE, HBLANK, VBLANK.
- WAIT_FRAME:
  - All pixels ignored.
  - vsync falling edge -> LINE with x=0, y=0, addr=0, line_err=0.
  - The block must observe vsync high before it can start, so no capture begins mid-frame.
- LINE, on lcd_pixel=1 with hsync=0 and vsync=0:
  - If x<WIDTH: shift the colour into the pack register; the first pixel of each byte lands in [7:6], the last in [1:0]. x increments.
  - On the 4th pixel of a byte, the next cycle drives fb_we=1 with fb_data=packed byte and fb_addr=current addr. addr then increments.
  - Write latency is 1 cycle after the 4th pixel is sampled.
  - If x==WIDTH: the pixel is dropped and line_err is set.
- LINE, on hsync rising edge:
  - If x!=WIDTH, set line_err.
  - If a partial byte is pending, pad the low bits with 00 and write it in the next cycle (same timing as a normal write).
  - y increments; x=0; line base += WIDTH/4; addr = new line base. Go to HBLANK.
- HBLANK:
  - Pixels are ignored.
  - hsync falling edge with vsync=0 -> LINE.
  - vsync rising edge -> VBLANK evaluation (see below).
- vsync rising edge, from LINE or HBLANK:
  - If it coincides with an hsync rise, the line close above happens first and the check uses the updated y.
  - Good frame = (y==HEIGHT && line_err==0): pulse frame_done and toggle fb_bank on the same cycle.
  - Otherwise pulse frame_err; fb_bank is unchanged.
  - In both cases go to VBLANK.
- VBLANK:
  - Pixels and hsync are ignored.
  - vsync falling edge -> LINE with x, y, addr, line base = 0 and line_err cleared.
  - If a pad-flush is pending at the vsync rise, it completes before the next frame starts. fb_we never overlaps a frame-start clear.
- y saturates at 255 with no wrap. Lines beyond HEIGHT are not written (fb_we is suppressed when y>=HEIGHT) and make the frame bad.
- cur_y = y. At most one fb_we per cycle; writes are never back-to-back faster than one per 4 pixels, except a pad-flush.
- Reset mid-operation: reset dominates all inputs; no write is issued in the reset cycle or the cycle after.

Test Plan:
- Reset, vsync 1->0, 144 lines of 160 pixels with colour = x[1:0], hsync after each line, then vsync rise -> 5760 writes, addr 0..5759 in order, every fb_data=8'h1B; frame_done pulses once; fb_bank 0->1; frame_err never asserted.
- Line 5 carries only 158 pixels -> line_err=1 at its hsync; pad write at addr 239 with fb_data low bits 0000; line 6 starts at addr 240; vsync rise gives frame_err pulse and fb_bank unchanged.
- Line 0 carries 161 pixels -> 40 writes only, 161st pixel dropped, line_err=1; next frame's vsync fall clears line_err.
- Stream starts mid-frame with vsync low (reset released at line 70) -> zero writes until first vsync 1->0; subsequent full frame gives frame_done.
- Only 143 lines before vsync rise -> cur_y=143, frame_err pulse, no frame_done, fb_bank unchanged.
- rst=0 asserted after 2 pixels of a byte -> no fb_we; outputs 0; state WAIT_FRAME; a following complete frame captures correctly from addr 0 with fb_bank=0.
